// File: rtl/snd_pkg.sv
// Shared types and constants for the sound sample-ROM loader path.
// Consumed by wave_loader; the sign conversion itself is selected there by WAVE_LOADER_SIGNCONV_EN.
package snd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdrLo,
        StHdrHi,
        StData,
        StDone
    } state_e;

    localparam int unsigned HDR_BYTES = 2;
    localparam logic [7:0]  SIGN_FLIP = 8'h80;

endpackage

// File: rtl/wave_loader.sv
// Captures one 8-bit wave image (2-byte LE length header + samples) from the ioctl download stream
// into wave RAM. Define WAVE_LOADER_SIGNCONV_EN to flip unsigned PCM to two's complement on write.
module wave_loader
    import snd_pkg::*;
#(
    parameter logic [7:0]  INDEX     = 8'd0,
    parameter logic [24:0] BASE_ADDR = 25'h0,
    parameter int unsigned RAM_AW    = 16
) (
    input  logic              clk,
    input  logic              RESET_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_we,
    output logic [15:0]       wav_length,
    output logic              loaded,
    output logic              err
);

    localparam int unsigned CW  = RAM_AW + 1;
    localparam int unsigned CAP = 1 << RAM_AW;

    state_e            state_q, state_d;
    logic              dl_q, dl_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [CW-1:0]     len_q, len_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;
    logic              ram_we_q, ram_we_d;
    logic [15:0]       wav_length_q, wav_length_d;
    logic              loaded_q, loaded_d;
    logic              err_q, err_d;

    logic        sel_dl;
    logic        dl_rise;
    logic        dl_fall;
    logic        accepted;
    logic [24:0] off;
    logic [24:0] exp_off;
    logic [15:0] hdr_len;
    logic [7:0]  wr_byte;

    assign sel_dl   = ioctl_download & (ioctl_index == INDEX);
    assign dl_rise  = sel_dl & ~dl_q;
    assign dl_fall  = ~sel_dl & dl_q;
    assign accepted = ioctl_wr & sel_dl & (ioctl_addr >= BASE_ADDR);
    assign off      = ioctl_addr - BASE_ADDR;
    assign exp_off  = 25'(cnt_q) + 25'(HDR_BYTES);
    assign hdr_len  = {ioctl_dout, len_lo_q};

`ifdef WAVE_LOADER_SIGNCONV_EN
    assign wr_byte = ioctl_dout ^ SIGN_FLIP;
`else
    assign wr_byte = ioctl_dout;
`endif

    always_comb begin
        state_d      = state_q;
        dl_d         = sel_dl;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        ram_we_d     = 1'b0;
        wav_length_d = wav_length_q;
        loaded_d     = loaded_q;
        err_d        = err_q;

        case (state_q)
            StIdle: begin
                if (dl_rise) begin
                    state_d      = StHdrLo;
                    loaded_d     = 1'b0;
                    err_d        = 1'b0;
                    wav_length_d = 16'd0;
                    cnt_d        = '0;
                    len_d        = '0;
                end
            end
            StHdrLo: begin
                if (accepted) begin
                    if (off == 25'd0) begin
                        len_lo_d = ioctl_dout;
                        state_d  = StHdrHi;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StHdrHi: begin
                if (accepted) begin
                    if (off == 25'd1) begin
                        // Images longer than the RAM are cut to capacity; the excess shows up as err.
                        if (32'(hdr_len) > CAP) begin
                            len_d = CW'(CAP);
                        end else begin
                            len_d = CW'(hdr_len);
                        end
                        state_d = (hdr_len == 16'd0) ? StDone : StData;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StData: begin
                if (accepted) begin
                    if (off == exp_off) begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = cnt_q[RAM_AW-1:0];
                        ram_data_d = wr_byte;
                        cnt_d      = cnt_q + 1'b1;
                        if (cnt_d == len_q) begin
                            state_d = StDone;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StDone: begin
                if (accepted) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // End of download publishes whatever was captured, even a truncated image.
        if (dl_fall && (state_q != StIdle)) begin
            wav_length_d = 16'(cnt_d);
            loaded_d     = 1'b1;
            state_d      = StIdle;
            if ((state_q == StHdrLo) || (state_q == StHdrHi)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q      <= StIdle;
            dl_q         <= 1'b0;
            len_lo_q     <= 8'd0;
            len_q        <= '0;
            cnt_q        <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= 8'd0;
            ram_we_q     <= 1'b0;
            wav_length_q <= 16'd0;
            loaded_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dl_q         <= dl_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            ram_we_q     <= ram_we_d;
            wav_length_q <= wav_length_d;
            loaded_q     <= loaded_d;
            err_q        <= err_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign ram_we     = ram_we_q;
    assign wav_length = wav_length_q;
    assign loaded     = loaded_q;
    assign err        = err_q;

endmodule

// File: tb/tb_wave_loader.sv
// Bench for wave_loader: two instances (RAM_AW=16 at index 0, RAM_AW=4 at index 3, base 0x10)
// share one ioctl bus, so each download is also foreign-index traffic for the other instance.
module tb_wave_loader;

    localparam logic [7:0]  IDX_A  = 8'd0;
    localparam logic [7:0]  IDX_B  = 8'd3;
    localparam logic [24:0] BASE_B = 25'h10;

    logic        clk = 1'b0;
    logic        RESET_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;

    logic [15:0] a_addr;
    logic [7:0]  a_data;
    logic        a_we;
    logic [15:0] a_wl;
    logic        a_loaded;
    logic        a_err;
    logic [3:0]  b_addr;
    logic [7:0]  b_data;
    logic        b_we;
    logic [15:0] b_wl;
    logic        b_loaded;
    logic        b_err;

    wave_loader #(.INDEX(IDX_A), .BASE_ADDR(25'h0), .RAM_AW(16)) dut_a (
        .clk(clk), .RESET_n(RESET_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ram_addr(a_addr), .ram_data(a_data), .ram_we(a_we), .wav_length(a_wl),
        .loaded(a_loaded), .err(a_err)
    );

    wave_loader #(.INDEX(IDX_B), .BASE_ADDR(BASE_B), .RAM_AW(4)) dut_b (
        .clk(clk), .RESET_n(RESET_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ram_addr(b_addr), .ram_data(b_data), .ram_we(b_we), .wav_length(b_wl),
        .loaded(b_loaded), .err(b_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic [31:0] c;
    } wr_t;

    wr_t        got_a[$];
    wr_t        got_b[$];
    wr_t        exp_q[$];
    logic [7:0] dbuf[$];
    int         n_pass = 0;
    int         n_chk = 0;

    // Every RAM write pulse is logged with the cycle it appeared in.
    always @(negedge clk) begin
        if (a_we) got_a.push_back({a_addr, a_data, 32'(cyc)});
        if (b_we) got_b.push_back({12'd0, b_addr, b_data, 32'(cyc)});
    end

    function automatic logic [7:0] model_conv(input logic [7:0] b);
`ifdef WAVE_LOADER_SIGNCONV_EN
        return {~b[7], b[6:0]};
`else
        return b;
`endif
    endfunction

    task automatic idle(input int k);
        @(posedge clk);
        #1 ioctl_wr = 1'b0;
        repeat (k - 1) @(posedge clk);
    endtask

    task automatic put_byte(input logic [24:0] a, input logic [7:0] d, output int c);
        @(posedge clk);
        #1;
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        c          = cyc;
    endtask

    task automatic start_dl(input bit to_b);
        @(posedge clk);
        #1;
        ioctl_wr       = 1'b0;
        ioctl_index    = to_b ? IDX_B : IDX_A;
        ioctl_download = 1'b1;
        got_a.delete();
        got_b.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic end_dl();
        @(posedge clk);
        #1;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    // Model: writes = first min(len, n) data bytes at addr 0.., one cycle after each strobe;
    // len = header clamped to RAM capacity; excess bytes raise err.
    task automatic send_image(input bit to_b, input int hdr, input int max_gap,
                              output int exp_wl, output bit exp_err);
        logic [24:0] base;
        logic [15:0] h;
        int cap, len, c, k;
        base = to_b ? BASE_B : 25'h0;
        cap  = to_b ? 16 : 65536;
        h    = 16'(hdr);
        len  = (hdr > cap) ? cap : hdr;
        start_dl(to_b);
        put_byte(base, h[7:0], c);
        put_byte(base + 25'd1, h[15:8], c);
        foreach (dbuf[i]) begin
            if (max_gap > 0) begin
                k = $urandom_range(0, max_gap);
                if (k > 0) idle(k);
            end
            put_byte(base + 25'(2 + i), dbuf[i], c);
            if (i < len) exp_q.push_back({16'(i), model_conv(dbuf[i]), 32'(c + 1)});
        end
        end_dl();
        exp_wl  = (dbuf.size() < len) ? dbuf.size() : len;
        exp_err = dbuf.size() > len;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({a_we, a_addr, a_data, a_wl, a_loaded, a_err} !== '0)
            $display("FAIL reset_a: got we=%b addr=%h data=%h wl=%0d ld=%b err=%b want all 0",
                     a_we, a_addr, a_data, a_wl, a_loaded, a_err);
        else n_pass++;
        n_chk++;
        if ({b_we, b_addr, b_data, b_wl, b_loaded, b_err} !== '0)
            $display("FAIL reset_b: got we=%b addr=%h data=%h wl=%0d ld=%b err=%b want all 0",
                     b_we, b_addr, b_data, b_wl, b_loaded, b_err);
        else n_pass++;
        @(posedge clk);
        #1 RESET_n = 1'b1;
    endtask

    task automatic test_image_a(input string name, input int hdr, input int max_gap);
        int  wl;
        bit  e;
        logic [15:0] b_wl_before;
        b_wl_before = b_wl;
        send_image(1'b0, hdr, max_gap, wl, e);
        n_chk++;
        if (got_a.size() !== exp_q.size())
            $display("FAIL %s_nwr: got %0d want %0d", name, got_a.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_a.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (got_a[i] !== exp_q[i])
                $display("FAIL %s_wr%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", name, i,
                         got_a[i].a, got_a[i].d, got_a[i].c, exp_q[i].a, exp_q[i].d, exp_q[i].c);
            else n_pass++;
        end
        n_chk++;
        if ({a_wl, a_loaded, a_err} !== {16'(wl), 1'b1, e})
            $display("FAIL %s_status: got wl=%0d ld=%b err=%b want wl=%0d ld=1 err=%b",
                     name, a_wl, a_loaded, a_err, wl, e);
        else n_pass++;
        n_chk++;
        if (got_b.size() != 0 || b_wl !== b_wl_before)
            $display("FAIL %s_other_idx: got b writes=%0d wl=%0d want 0 writes wl=%0d",
                     name, got_b.size(), b_wl, b_wl_before);
        else n_pass++;
    endtask

    task automatic test_basic();
        dbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
        test_image_a("basic", 4, 0);
    endtask

    task automatic test_signconv();
        dbuf = '{8'h00, 8'h80, 8'hFF};
        test_image_a("signconv", 3, 1);
    endtask

    task automatic test_short();
        dbuf = '{8'hA1, 8'hA2, 8'hA3};
        test_image_a("short", 5, 0);
    endtask

    task automatic test_overflow();
        dbuf = '{8'h01, 8'h02, 8'h03, 8'h04};
        test_image_a("overflow", 2, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(0, 12);
            dbuf.delete();
            for (int j = 0; j < n; j++) dbuf.push_back(8'($urandom));
            test_image_a($sformatf("rand%0d", it), $urandom_range(0, 10), 2);
        end
    endtask

    task automatic test_out_of_order();
        int c;
        start_dl(1'b0);
        put_byte(25'd0, 8'h04, c);
        put_byte(25'd1, 8'h00, c);
        put_byte(25'd2, 8'hC0, c);
        exp_q.push_back({16'd0, model_conv(8'hC0), 32'(c + 1)});
        put_byte(25'd4, 8'hC2, c);
        put_byte(25'd3, 8'hC1, c);
        exp_q.push_back({16'd1, model_conv(8'hC1), 32'(c + 1)});
        end_dl();
        n_chk++;
        if (got_a.size() !== 2 || got_a[0] !== exp_q[0] || got_a[1] !== exp_q[1])
            $display("FAIL ooo_writes: got %0d writes want 2 (addr0=C0 addr1=C1 in order)",
                     got_a.size());
        else n_pass++;
        n_chk++;
        if ({a_wl, a_loaded, a_err} !== {16'd2, 1'b1, 1'b1})
            $display("FAIL ooo_status: got wl=%0d ld=%b err=%b want wl=2 ld=1 err=1",
                     a_wl, a_loaded, a_err);
        else n_pass++;
    endtask

    task automatic test_reload_abort();
        @(posedge clk);
        #1;
        ioctl_index    = IDX_A;
        ioctl_download = 1'b1;
        @(negedge clk);
        n_chk++;
        if (a_loaded !== 1'b1) $display("FAIL reload_pre: got ld=%b want 1", a_loaded);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({a_loaded, a_err, a_wl} !== {1'b0, 1'b0, 16'd0})
            $display("FAIL reload_clear: got ld=%b err=%b wl=%0d want 0 0 0",
                     a_loaded, a_err, a_wl);
        else n_pass++;
        end_dl();
        n_chk++;
        if ({a_wl, a_loaded, a_err} !== {16'd0, 1'b1, 1'b1})
            $display("FAIL hdr_abort: got wl=%0d ld=%b err=%b want wl=0 ld=1 err=1",
                     a_wl, a_loaded, a_err);
        else n_pass++;
    endtask

    task automatic test_clamp();
        int  wl;
        bit  e;
        logic [15:0] a_wl_before;
        a_wl_before = a_wl;
        dbuf.delete();
        for (int j = 0; j < 20; j++) dbuf.push_back(8'($urandom));
        send_image(1'b1, 16'h0100, 1, wl, e);
        n_chk++;
        if (got_b.size() !== exp_q.size())
            $display("FAIL clamp_nwr: got %0d want %0d", got_b.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_b.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (got_b[i] !== exp_q[i])
                $display("FAIL clamp_wr%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i,
                         got_b[i].a, got_b[i].d, got_b[i].c, exp_q[i].a, exp_q[i].d, exp_q[i].c);
            else n_pass++;
        end
        n_chk++;
        if ({b_wl, b_loaded, b_err} !== {16'(wl), 1'b1, e} || wl != 16)
            $display("FAIL clamp_status: got wl=%0d ld=%b err=%b want wl=16 ld=1 err=1",
                     b_wl, b_loaded, b_err);
        else n_pass++;
        n_chk++;
        if (got_a.size() != 0 || a_wl !== a_wl_before)
            $display("FAIL clamp_other_idx: got a writes=%0d wl=%0d want 0 writes wl=%0d",
                     got_a.size(), a_wl, a_wl_before);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int c;
        start_dl(1'b0);
        put_byte(25'd0, 8'h06, c);
        put_byte(25'd1, 8'h00, c);
        put_byte(25'd5, 8'hAA, c);
        put_byte(25'd2, 8'h5A, c);
        @(posedge clk);
        #2;
        n_chk++;
        if ({a_we, a_err} !== 2'b11)
            $display("FAIL rstmid_pre: got we=%b err=%b want 1 1", a_we, a_err);
        else n_pass++;
        RESET_n = 1'b0;
        #1;
        n_chk++;
        if ({a_we, a_data, a_wl, a_loaded, a_err} !== '0)
            $display("FAIL rstmid_a: got we=%b data=%h wl=%0d ld=%b err=%b want all 0",
                     a_we, a_data, a_wl, a_loaded, a_err);
        else n_pass++;
        n_chk++;
        if ({b_wl, b_loaded, b_err} !== '0)
            $display("FAIL rstmid_b: got wl=%0d ld=%b err=%b want all 0", b_wl, b_loaded, b_err);
        else n_pass++;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        repeat (2) @(posedge clk);
        #1 RESET_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({a_we, a_loaded, a_err} !== 3'b000)
            $display("FAIL rstmid_post: got we=%b ld=%b err=%b want 0 0 0", a_we, a_loaded, a_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signconv();
        test_short();
        test_overflow();
        test_out_of_order();
        test_reload_abort();
        test_random();
        test_clamp();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
